// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a DEPTH-entry prefetch buffer and credit-limited memory requests.
// Define IF_PREFETCH_PERF_EN to add the perf_stall_cycles_op/perf_dropped_op/perf_empty_cycles_op counters.
module if_prefetch_stage #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall_ip,
    input  logic            flush_en,
    input  logic [XLEN-1:0] flush_target_ip,
    output logic            instr_req_op,
    output logic [XLEN-1:0] instr_addr_op,
    input  logic            instr_gnt_ip,
    input  logic            instr_rvalid_ip,
    input  logic [XLEN-1:0] instr_rdata_ip,
    output logic            instr_valid_op,
    output logic [XLEN-1:0] instr_data_op,
    output logic [XLEN-1:0] instr_pc_addr_op
`ifdef IF_PREFETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cycles_op,
    output logic [31:0]     perf_dropped_op,
    output logic [31:0]     perf_empty_cycles_op
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]   ONE_C = CW'(1);
    localparam logic [PW-1:0]   ONE_P = PW'(1);
    localparam logic [XLEN-1:0] STEP  = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] pc_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_d [DEPTH];
    logic [XLEN-1:0] data_mem_q [DEPTH];
    logic [XLEN-1:0] data_mem_d [DEPTH];

    logic [CW:0] credit_used;
    logic        gnt_hs;
    logic        rsp_dec;
    logic        consume;
    logic        wr_en;

    // Outstanding requests and buffered entries share one credit pool, so a write can never overflow.
    assign credit_used  = {1'b0, outst_q} + {1'b0, count_q};
    assign instr_req_op = !reset && !flush_en && (credit_used < (CW + 1)'(DEPTH));
    assign instr_addr_op = fetch_pc_q;
    assign gnt_hs  = instr_req_op && instr_gnt_ip;
    assign rsp_dec = instr_rvalid_ip && (outst_q != '0);
    assign consume = instr_valid_op && !stall_ip;

    assign instr_valid_op   = (count_q != '0);
    assign instr_data_op    = data_mem_q[rd_ptr_q];
    assign instr_pc_addr_op = pc_mem_q[rd_ptr_q];

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        outst_d    = outst_q;
        drop_d     = drop_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        pc_mem_d   = pc_mem_q;
        data_mem_d = data_mem_q;
        wr_en      = 1'b0;

        if (gnt_hs && !rsp_dec) begin
            outst_d = outst_q + ONE_C;
        end else if (!gnt_hs && rsp_dec) begin
            outst_d = outst_q - ONE_C;
        end

        if (flush_en) begin
            // No grant can happen in a flush cycle, so every still-pending response is stale.
            fetch_pc_d = flush_target_ip;
            resp_pc_d  = flush_target_ip;
            drop_d     = outst_d;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            if (gnt_hs) begin
                fetch_pc_d = fetch_pc_q + STEP;
            end
            if (instr_rvalid_ip) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - ONE_C;
                end else begin
                    wr_en                = 1'b1;
                    pc_mem_d[wr_ptr_q]   = resp_pc_q;
                    data_mem_d[wr_ptr_q] = instr_rdata_ip;
                    wr_ptr_d             = wr_ptr_q + ONE_P;
                    resp_pc_d            = resp_pc_q + STEP;
                end
            end
            if (consume) begin
                rd_ptr_d = rd_ptr_q + ONE_P;
            end
            case ({wr_en, consume})
                2'b10:   count_d = count_q + ONE_C;
                2'b01:   count_d = count_q - ONE_C;
                default: count_d = count_q;
            endcase
        end
    end

`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_drop_q, perf_drop_d;
    logic [31:0] perf_empty_q, perf_empty_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_drop_d  = perf_drop_q;
        perf_empty_d = perf_empty_q;
        if (instr_valid_op && stall_ip && !(&perf_stall_q)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (instr_rvalid_ip && (flush_en || (drop_q != '0)) && !(&perf_drop_q)) begin
            perf_drop_d = perf_drop_q + 32'd1;
        end
        if (!instr_valid_op && !flush_en && !(&perf_empty_q)) begin
            perf_empty_d = perf_empty_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_drop_q  <= '0;
            perf_empty_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_drop_q  <= perf_drop_d;
            perf_empty_q <= perf_empty_d;
        end
    end

    assign perf_stall_cycles_op = perf_stall_q;
    assign perf_dropped_op      = perf_drop_q;
    assign perf_empty_cycles_op = perf_empty_q;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            outst_q    <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            outst_q    <= outst_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            pc_mem_q   <= pc_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: in-order variable-latency memory, epoch-tagged delivery model,
// a directed vector table, hand-written corner sequences and a randomized run.
module tb_if_prefetch_stage;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clock, reset, stall_ip, flush_en;
    logic [31:0] flush_target_ip;
    logic        instr_req_op, instr_gnt_ip, instr_rvalid_ip, instr_valid_op;
    logic [31:0] instr_addr_op, instr_rdata_ip, instr_data_op, instr_pc_addr_op;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] perf_stall_cycles_op, perf_dropped_op, perf_empty_cycles_op;
`endif

    if_prefetch_stage #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clock(clock), .reset(reset), .stall_ip(stall_ip), .flush_en(flush_en),
        .flush_target_ip(flush_target_ip), .instr_req_op(instr_req_op),
        .instr_addr_op(instr_addr_op), .instr_gnt_ip(instr_gnt_ip),
        .instr_rvalid_ip(instr_rvalid_ip), .instr_rdata_ip(instr_rdata_ip),
        .instr_valid_op(instr_valid_op), .instr_data_op(instr_data_op),
        .instr_pc_addr_op(instr_pc_addr_op)
`ifdef IF_PREFETCH_PERF_EN
        , .perf_stall_cycles_op(perf_stall_cycles_op), .perf_dropped_op(perf_dropped_op),
        .perf_empty_cycles_op(perf_empty_cycles_op)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct { logic [31:0] addr; int ep; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct {
        logic st; logic fl; logic [31:0] tg; logic gn;
        logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
    } vec_t;

    mreq_t mem_q[$];   // granted, not yet answered (memory + in-flight view)
    ent_t  buf_q[$];   // instructions Decode is still owed, in order
    int n_chk = 0, n_fail = 0, cyc = 0, epoch = 0, n_grants = 0;
    int lat_min = 1, lat_max = 1;
    logic [31:0] m_fetch = RESET_PC;
    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_data;
`ifdef IF_PREFETCH_PERF_EN
    logic [31:0] m_pstall = '0, m_pdrop = '0, m_pempty = '0;
`endif

    function automatic logic [31:0] mw(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_F00D;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input logic st, input logic fl, input logic [31:0] tg,
                        input logic gn, input logic rs);
        logic rv, gnt_ev, cons, emp, exp_req;
        mreq_t e;
        stall_ip = st; flush_en = fl; flush_target_ip = tg; instr_gnt_ip = gn; reset = rs;
        rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        instr_rvalid_ip = rv;
        instr_rdata_ip  = rv ? mw(mem_q[0].addr) : 32'hDEAD_BEEF;
        @(negedge clock);
        s_req = instr_req_op; s_addr = instr_addr_op; s_valid = instr_valid_op;
        s_pc = instr_pc_addr_op; s_data = instr_data_op;
        exp_req = !rs && !fl && ((mem_q.size() + buf_q.size()) < DEPTH);
        chk("req", {31'b0, instr_req_op}, {31'b0, exp_req});
        if (exp_req) chk("addr", instr_addr_op, m_fetch);
        chk("valid", {31'b0, instr_valid_op}, {31'b0, buf_q.size() != 0});
        if (buf_q.size() != 0) begin
            chk("head_pc", instr_pc_addr_op, buf_q[0].pc);
            chk("head_data", instr_data_op, buf_q[0].data);
        end
`ifdef IF_PREFETCH_PERF_EN
        chk("perf_stall", perf_stall_cycles_op, m_pstall);
        chk("perf_drop", perf_dropped_op, m_pdrop);
        chk("perf_empty", perf_empty_cycles_op, m_pempty);
`endif
        gnt_ev = instr_req_op && gn;
        cons   = (buf_q.size() != 0) && !st;
        emp    = (buf_q.size() == 0);
        @(posedge clock);
        if (rs) begin
            mem_q.delete(); buf_q.delete(); m_fetch = RESET_PC; epoch++;
`ifdef IF_PREFETCH_PERF_EN
            m_pstall = '0; m_pdrop = '0; m_pempty = '0;
`endif
        end else begin
`ifdef IF_PREFETCH_PERF_EN
            if (!emp && st) m_pstall = sat_inc(m_pstall);
            if (emp && !fl) m_pempty = sat_inc(m_pempty);
`endif
            if (rv) begin
                e = mem_q.pop_front();
                if (!fl && e.ep == epoch) buf_q.push_back('{e.addr, mw(e.addr)});
`ifdef IF_PREFETCH_PERF_EN
                else m_pdrop = sat_inc(m_pdrop);
`endif
            end
            if (fl) begin
                buf_q.delete(); epoch++; m_fetch = tg;
            end else begin
                if (cons) void'(buf_q.pop_front());
                if (gnt_ev) begin
                    mem_q.push_back('{m_fetch, epoch, cyc + int'($urandom_range(lat_max, lat_min))});
                    m_fetch = m_fetch + 32'd4;
                    n_grants++;
                end
            end
        end
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vec[12];
        int g0;
        logic [31:0] a0, t0;
        logic [31:0] pcs[3];
        int got;
`ifdef IF_PREFETCH_PERF_EN
        logic [31:0] d0;
`endif

        reset = 1'b1; stall_ip = 1'b0; flush_en = 1'b0; flush_target_ip = '0;
        instr_gnt_ip = 1'b1; instr_rvalid_ip = 1'b0; instr_rdata_ip = '0;
        @(posedge clock); #1;

        // Reset state
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        chk("rst_req", {31'b0, s_req}, 32'd0);
        chk("rst_valid", {31'b0, s_valid}, 32'd0);
        chk("rst_data", s_data, 32'd0);
        chk("rst_pc", s_pc, 32'd0);

        // Sequential fetch, redirect latency and a one-cycle stall, 1-cycle memory
        vec[0]  = '{0, 0, 0,        1, 1, 32'h000, 0, 32'h000};
        vec[1]  = '{0, 0, 0,        1, 1, 32'h004, 0, 32'h000};
        vec[2]  = '{0, 0, 0,        1, 1, 32'h008, 1, 32'h000};
        vec[3]  = '{0, 0, 0,        1, 1, 32'h00C, 1, 32'h004};
        vec[4]  = '{0, 1, 32'h100,  1, 0, 32'h000, 1, 32'h008};
        vec[5]  = '{0, 0, 0,        1, 1, 32'h100, 0, 32'h000};
        vec[6]  = '{0, 0, 0,        1, 1, 32'h104, 0, 32'h000};
        vec[7]  = '{0, 0, 0,        1, 1, 32'h108, 1, 32'h100};
        vec[8]  = '{0, 0, 0,        1, 1, 32'h10C, 1, 32'h104};
        vec[9]  = '{1, 0, 0,        1, 1, 32'h110, 1, 32'h108};
        vec[10] = '{0, 0, 0,        1, 1, 32'h114, 1, 32'h108};
        vec[11] = '{0, 0, 0,        1, 1, 32'h118, 1, 32'h10C};
        for (int i = 0; i < 12; i++) begin
            step(vec[i].st, vec[i].fl, vec[i].tg, vec[i].gn, 0);
            chk("tbl_req", {31'b0, s_req}, {31'b0, vec[i].e_req});
            if (vec[i].e_req) chk("tbl_addr", s_addr, vec[i].e_addr);
            chk("tbl_valid", {31'b0, s_valid}, {31'b0, vec[i].e_valid});
            if (vec[i].e_valid) begin
                chk("tbl_pc", s_pc, vec[i].e_pc);
                chk("tbl_data", s_data, mw(vec[i].e_pc));
            end
        end

        // Stall fill: exactly DEPTH requests, then requests stop and the head holds
        step(1, 1, 32'h200, 1, 0);
        g0 = n_grants;
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
        chk("fill_grants", n_grants - g0, DEPTH);
        chk("fill_req_off", {31'b0, s_req}, 32'd0);
        chk("fill_head_valid", {31'b0, s_valid}, 32'd1);
        chk("fill_head_pc", s_pc, 32'h200);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0);

        // Grant backpressure: request and address held
        step(0, 0, 0, 0, 0);
        a0 = s_addr;
        chk("bp_req", {31'b0, s_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0);
            chk("bp_req", {31'b0, s_req}, 32'd1);
            chk("bp_addr", s_addr, a0);
        end
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0);

        // Redirect with three requests in flight, 3-cycle memory
        lat_min = 3; lat_max = 3;
        step(0, 1, 32'h40, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
`ifdef IF_PREFETCH_PERF_EN
        d0 = m_pdrop;
`endif
        step(0, 1, 32'h100, 1, 0);
        got = 0;
        for (int i = 0; i < 30 && got == 0; i++) begin
            step(0, 0, 0, 1, 0);
            if (s_valid) begin
                got = 1;
                chk("redir_first_pc", s_pc, 32'h100);
            end
        end
        if (got == 0) chk("redir_timeout", 32'd0, 32'd1);
`ifdef IF_PREFETCH_PERF_EN
        chk("redir_dropped3", perf_dropped_op, d0 + 32'd3);
`endif

        // Flush + stall + rvalid in one cycle, 1-cycle memory
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);
        step(1, 1, 32'h300, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("ffs_empty", {31'b0, s_valid}, 32'd0);
        chk("ffs_req", {31'b0, s_req}, 32'd1);
        chk("ffs_addr", s_addr, 32'h300);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0);

        // Reset with a full buffer
        for (int i = 0; i < 10; i++) step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 1);
        step(0, 0, 0, 1, 0);
        chk("mrst_valid", {31'b0, s_valid}, 32'd0);
        chk("mrst_data", s_data, 32'd0);
        chk("mrst_pc", s_pc, 32'd0);
        chk("mrst_req", {31'b0, s_req}, 32'd1);
        chk("mrst_addr", s_addr, RESET_PC);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0);

        // PC wrap past the top of the address space
        step(0, 1, 32'hFFFF_FFF8, 1, 0);
        got = 0;
        for (int i = 0; i < 20 && got < 3; i++) begin
            step(0, 0, 0, 1, 0);
            if (s_valid) begin
                pcs[got] = s_pc;
                got++;
            end
        end
        if (got == 3) begin
            chk("wrap_pc0", pcs[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", pcs[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", pcs[2], 32'h0000_0000);
        end else begin
            chk("wrap_timeout", got, 32'd3);
        end

        // Randomized traffic against the delivery model
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            t0 = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) t0 = 32'hFFFF_FFF0 | (t0 & 32'hC);
            step($urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0, t0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage for the 5-stage RISC-V core: replaces the single-entry IF/ID register with a DEPTH-entry prefetch buffer and supports a variable-latency, in-order instruction memory with up to DEPTH outstanding requests. It sits between instruction memory and Decode. Decode stall and Execute redirect/flush are handled without losing or duplicating instructions. Responses already in flight at a redirect are discarded.

## Interface
- XLEN, 32, address/data width
- DEPTH, 4, prefetch buffer entries and outstanding-request limit (power of 2, >=2)
- RESET_PC, 32'h0, PC fetched first after reset
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- stall_ip  in  1  Decode stall; head instruction is not consumed
- flush_en  in  1  redirect from Execute flush controller
- flush_target_ip  in  XLEN  redirect PC, sampled when flush_en=1
- instr_req_op  out  1  memory request valid
- instr_addr_op  out  XLEN  request address (word aligned)
- instr_gnt_ip  in  1  request accepted this cycle when instr_req_op=1
- instr_rvalid_ip  in  1  response valid; responses return in grant order, >=1 cycle after grant
- instr_rdata_ip  in  XLEN  response instruction word
- instr_valid_op  out  1  buffer head valid to Decode
- instr_data_op  out  XLEN  head instruction
- instr_pc_addr_op  out  XLEN  head PC

## Operation
- State: fetch_pc (next request address), resp_pc (PC of next accepted response), outstanding count (0..DEPTH), drop count (0..DEPTH), circular buffer of {pc,data}, DEPTH entries, rd/wr pointers plus count.
- Issue: instr_req_op = !reset && !flush_en && (outstanding + buf_count) < DEPTH; instr_addr_op = fetch_pc. Handshake on req&&gnt: fetch_pc += 4, outstanding += 1. instr_req_op and instr_addr_op held stable until granted.
- Response: on rvalid, outstanding -= 1. If drop count > 0: drop count -= 1, data discarded. Otherwise write {resp_pc, rdata} at wr pointer, resp_pc += 4. Credit rule guarantees no overflow.
- Consume: when instr_valid_op && !stall_ip, rd pointer advances. Write and read in the same cycle are both performed; count is unchanged.
- Redirect (flush_en=1): buffer emptied, fetch_pc and resp_pc <= flush_target_ip, drop count <= outstanding - rvalid, no request issued that cycle. A response arriving in the flush cycle is dropped. Flush takes priority over stall and over any concurrent write or read. A flush during an active drop recomputes drop count from outstanding, so all older responses are still discarded.
- Arithmetic: PC increments are modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0. Counters never exceed DEPTH and never go below 0.

## Timing
- Reset: instr_req_op=0, instr_valid_op=0, instr_data_op=0, instr_pc_addr_op=0. Pointers and counters are 0. fetch_pc=resp_pc=RESET_PC. The first request is asserted in the first cycle with reset=0.
- Outputs to Decode are registered buffer contents, show-ahead. A response written at edge E is visible from E onward, so rvalid in cycle N gives instr_valid_op in cycle N+1.
- Redirect latency with 1-cycle memory and gnt=1: flush_en in cycle N, request to target in N+1, rvalid in N+2, instr_valid_op with target PC in N+3.
- Steady state with gnt=1, 1-cycle memory, no stall: one instruction per cycle.
- Full buffer: requests stop once outstanding + buf_count reaches DEPTH and resume the cycle after a consume.
- Reset asserted mid-operation: all state returns to reset values at that edge. Responses to pre-reset requests are not expected; the memory is reset together with this block.

## Configuration
- IF_PREFETCH_PERF_EN defined: adds outputs perf_stall_cycles_op (32 bit, counts cycles with instr_valid_op && stall_ip), perf_dropped_op (32 bit, counts discarded responses), and perf_empty_cycles_op (32 bit, counts cycles with the buffer empty and no flush). All three are cleared by reset and saturate at all-ones.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Sequential fetch: gnt=1, 1-cycle memory, RESET_PC=0, no stall -> instr_pc_addr_op sequence 0,4,8,... one per cycle, data matches memory.
- Stall fill: stall_ip=1 for 10 cycles -> exactly DEPTH=4 requests issued, instr_req_op=0 afterwards, head PC held. On release the PCs resume in order with no gap or duplicate.
- Redirect with in-flight: 3-cycle memory, 3 outstanding, flush_en with target 32'h100 -> the 3 old responses are dropped, the next valid instruction has PC 32'h100, perf_dropped_op=3 when the macro is defined.
- Grant backpressure: gnt=0 for 5 cycles -> instr_req_op stays 1 and instr_addr_op stays constant; after gnt the sequence is unbroken.
- Simultaneous flush+stall+rvalid: all asserted in one cycle -> buffer empty next cycle, response dropped, fetch restarts at target.
- Reset mid-stream and wrap: reset with the buffer full -> outputs 0 the next cycle and refetch from RESET_PC. Separately, a target of 32'hFFFF_FFF8 gives following PCs 32'hFFFF_FFFC and then 0.
